// File: rtl/prim_ff_checker.sv
// Response checker for DFF/DFFE/SRFFE primitives: runs a cycle-accurate model
// alongside the primitive under test and scores dut_q against it over a fixed window.

module prim_ff_checker_lane #(
  parameter int MODE = 0
) (
  input  logic clk,
  input  logic clrn,
  input  logic ena,
  input  logic d,
  input  logic s,
  input  logic r,
  output logic q
);
  logic nxt;

  // Conflicting set/reset holds, same as idle set/reset.
  always_comb begin
    nxt = q;
    case (MODE)
      0:       nxt = d;
      1:       if (ena) nxt = d;
      default: if (ena && (s ^ r)) nxt = s;
    endcase
  end

  always_ff @(posedge clk or negedge clrn)
    if (!clrn) q <= 1'b0;
    else       q <= nxt;
endmodule

module prim_ff_checker #(
  parameter int WIDTH     = 8,
  parameter int MODE      = 0,
  parameter int CHECK_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic             ena,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] dut_q,
  output logic [WIDTH-1:0] model_q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_mask
);
  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(CHECK_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] idx;
  logic [WIDTH-1:0] diff;
  logic             mismatch;
  logic [CNT_W-1:0] err_nxt;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    prim_ff_checker_lane #(.MODE(MODE)) u_lane (
      .clk (clk),
      .clrn(clrn),
      .ena (ena),
      .d   (d[g]),
      .s   (s[g]),
      .r   (r[g]),
      .q   (model_q[g])
    );
  end

  assign diff     = dut_q ^ model_q;
  assign mismatch = |diff;
  assign err_nxt  = (mismatch && err_cnt != CNT_MAX) ? err_cnt + 1'b1 : err_cnt;

  // err_cnt saturates rather than wrapping, so err_cnt == 0 marks "no mismatch yet".
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state          <= IDLE;
      idx            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_idx  <= '0;
      first_err_mask <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= CHECK;
            idx            <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_idx  <= '0;
            first_err_mask <= '0;
          end
        end
        CHECK: begin
          err_cnt <= err_nxt;
          idx     <= idx + 1'b1;
          if (mismatch && err_cnt == '0) begin
            first_err_idx  <= idx;
            first_err_mask <= diff;
          end
          if (idx == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prim_ff_checker.sv
// Directed bench for prim_ff_checker: one instance per model mode plus a narrow-counter
// instance, paired with reference primitives or forced dut_q values.

module tb_prim_ff_checker;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // u0: DFF, CNT_W=8
  logic start0 = 0, use_ref0 = 0;
  logic [7:0] d0 = 0, force0 = 0, ref0, dq0, mq0, fm0;
  logic [7:0] ec0, fi0;
  logic busy0, done0, pass0;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) ref0 <= '0; else ref0 <= d0;
  assign dq0 = use_ref0 ? ref0 : force0;

  prim_ff_checker #(.WIDTH(8), .MODE(0), .CHECK_LEN(16), .CNT_W(8)) u0 (
    .clk(clk), .clrn(clrn), .start(start0), .ena(1'b0), .d(d0), .s(8'h00), .r(8'h00),
    .dut_q(dq0), .model_q(mq0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(ec0), .first_err_idx(fi0), .first_err_mask(fm0));

  // u1: DFFE
  logic start1 = 0, ena1 = 0;
  logic [7:0] d1 = 0, dq1 = 0, mq1, fm1, ec1, fi1;
  logic busy1, done1, pass1;

  prim_ff_checker #(.WIDTH(8), .MODE(1), .CHECK_LEN(16), .CNT_W(8)) u1 (
    .clk(clk), .clrn(clrn), .start(start1), .ena(ena1), .d(d1), .s(8'h00), .r(8'h00),
    .dut_q(dq1), .model_q(mq1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(ec1), .first_err_idx(fi1), .first_err_mask(fm1));

  // u2: SRFFE, paired with a reference SRFFE
  logic start2 = 0, ena2 = 0;
  logic [7:0] s2 = 0, r2 = 0, ref2, mq2, fm2, ec2, fi2;
  logic busy2, done2, pass2;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) ref2 <= '0;
    else if (ena2) ref2 <= (ref2 & ~(s2 ^ r2)) | (s2 & ~r2);

  prim_ff_checker #(.WIDTH(8), .MODE(2), .CHECK_LEN(16), .CNT_W(8)) u2 (
    .clk(clk), .clrn(clrn), .start(start2), .ena(ena2), .d(8'h00), .s(s2), .r(r2),
    .dut_q(ref2), .model_q(mq2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(ec2), .first_err_idx(fi2), .first_err_mask(fm2));

  // u3: DFF with a 4-bit counter
  logic start3 = 0;
  logic [7:0] d3 = 0, dq3 = 0, mq3, fm3;
  logic [3:0] ec3, fi3;
  logic busy3, done3, pass3;

  prim_ff_checker #(.WIDTH(8), .MODE(0), .CHECK_LEN(16), .CNT_W(4)) u3 (
    .clk(clk), .clrn(clrn), .start(start3), .ena(1'b0), .d(d3), .s(8'h00), .r(8'h00),
    .dut_q(dq3), .model_q(mq3), .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(ec3), .first_err_idx(fi3), .first_err_mask(fm3));

  task automatic test_reset();
    d0 = 8'h5A;
    #1;
    checks++; if (mq0 !== 8'h00) begin errors++; $display("FAIL reset_model_q: got %h want 00", mq0); end
    checks++; if ({busy0, done0, pass0} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy0, done0, pass0}); end
    checks++; if ({ec0, fi0, fm0} !== 24'h0) begin errors++; $display("FAIL reset_results: got %h want 000000", {ec0, fi0, fm0}); end
    @(negedge clk);
    clrn = 1'b1;
    d0 = 8'h00;
  endtask

  // DFF paired with a reference DFF, d toggling every 3 cycles
  task automatic test_dff_pass();
    use_ref0 = 1'b1;
    d0 = 8'h00;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL dff_busy_after_start: got %b want 1", busy0); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i % 3 == 0) d0 = ~d0;
      if (i == 14) begin
        checks++; if ({busy0, done0} !== 2'b10) begin errors++; $display("FAIL dff_not_done_early: got %b want 10", {busy0, done0}); end
      end
    end
    checks++; if ({busy0, done0, pass0} !== 3'b011) begin errors++; $display("FAIL dff_done_pass: got %b want 011", {busy0, done0, pass0}); end
    checks++; if (ec0 !== 8'd0) begin errors++; $display("FAIL dff_err_cnt: got %0d want 0", ec0); end
  endtask

  // Bit 3 stuck low; rerun from DONE
  task automatic test_stuck_bit();
    use_ref0 = 1'b0;
    force0 = 8'hF7;
    d0 = 8'hFF;
    @(negedge clk);
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    checks++; if ({busy0, done0, pass0} !== 3'b100) begin errors++; $display("FAIL rerun_drops_done: got %b want 100", {busy0, done0, pass0}); end
    repeat (16) @(negedge clk);
    checks++; if (ec0 !== 8'd16) begin errors++; $display("FAIL stuck_err_cnt: got %0d want 16", ec0); end
    checks++; if (fi0 !== 8'd0) begin errors++; $display("FAIL stuck_first_idx: got %0d want 0", fi0); end
    checks++; if (fm0 !== 8'h08) begin errors++; $display("FAIL stuck_first_mask: got %h want 08", fm0); end
    checks++; if ({done0, pass0} !== 2'b10) begin errors++; $display("FAIL stuck_done_pass: got %b want 10", {done0, pass0}); end
    repeat (3) @(negedge clk);
    checks++; if ({done0, ec0} !== 9'h110) begin errors++; $display("FAIL done_holds: got %h want 110", {done0, ec0}); end
  endtask

  task automatic test_srffe();
    ena2 = 1'b1;
    s2 = 8'hFF; r2 = 8'h00;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    checks++; if (mq2 !== 8'hFF) begin errors++; $display("FAIL sr_set: got %h want FF", mq2); end
    s2 = 8'hFF; r2 = 8'hFF;
    @(negedge clk);
    checks++; if (mq2 !== 8'hFF) begin errors++; $display("FAIL sr_both_hold: got %h want FF", mq2); end
    s2 = 8'h00; r2 = 8'hFF;
    @(negedge clk);
    checks++; if (mq2 !== 8'h00) begin errors++; $display("FAIL sr_reset: got %h want 00", mq2); end
    s2 = 8'h00; r2 = 8'h00;
    repeat (14) @(negedge clk);
    checks++; if ({done2, pass2, ec2} !== 10'b11_0000_0000) begin errors++; $display("FAIL sr_pass: got %b want 1100000000", {done2, pass2, ec2}); end
  endtask

  // Enable low: model holds reset value, dut_q diverges from index 5
  task automatic test_enable_hold();
    ena1 = 1'b0; d1 = 8'hAA; dq1 = 8'h00;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (5) @(negedge clk);
    dq1 = 8'hAA;
    repeat (11) @(negedge clk);
    checks++; if (mq1 !== 8'h00) begin errors++; $display("FAIL ena_model_hold: got %h want 00", mq1); end
    checks++; if (ec1 !== 8'd11) begin errors++; $display("FAIL ena_err_cnt: got %0d want 11", ec1); end
    checks++; if (fi1 !== 8'd5) begin errors++; $display("FAIL ena_first_idx: got %0d want 5", fi1); end
    checks++; if (fm1 !== 8'hAA) begin errors++; $display("FAIL ena_first_mask: got %h want AA", fm1); end
    checks++; if ({done1, pass1} !== 2'b10) begin errors++; $display("FAIL ena_done_pass: got %b want 10", {done1, pass1}); end
  endtask

  task automatic test_saturate();
    d3 = 8'h00; dq3 = 8'hFF;
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    repeat (16) @(negedge clk);
    checks++; if (ec3 !== 4'hF) begin errors++; $display("FAIL sat_err_cnt: got %0d want 15", ec3); end
    checks++; if ({done3, pass3} !== 2'b10) begin errors++; $display("FAIL sat_done_pass: got %b want 10", {done3, pass3}); end
    checks++; if ({fi3, fm3} !== 12'h0FF) begin errors++; $display("FAIL sat_first: got %h want 0FF", {fi3, fm3}); end
  endtask

  task automatic test_reset_mid_run();
    use_ref0 = 1'b0; force0 = 8'h00; d0 = 8'h3C;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (7) @(negedge clk);
    clrn = 1'b0;
    #1;
    checks++; if ({busy0, done0, pass0} !== 3'b000) begin errors++; $display("FAIL mid_reset_flags: got %b want 000", {busy0, done0, pass0}); end
    checks++; if ({ec0, fi0, fm0, mq0} !== 32'h0) begin errors++; $display("FAIL mid_reset_regs: got %h want 00000000", {ec0, fi0, fm0, mq0}); end
    @(negedge clk); clrn = 1'b1;
    use_ref0 = 1'b1;
    @(negedge clk);
    checks++; if ({busy0, done0} !== 2'b00) begin errors++; $display("FAIL mid_reset_idle: got %b want 00", {busy0, done0}); end
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start0 = (i == 5);
      if (i % 2 == 0) d0 = d0 + 8'h11;
      if (i == 14) begin
        checks++; if ({busy0, done0} !== 2'b10) begin errors++; $display("FAIL start_in_check_ignored: got %b want 10", {busy0, done0}); end
      end
    end
    start0 = 1'b0;
    checks++; if ({done0, pass0, ec0} !== 10'b11_0000_0000) begin errors++; $display("FAIL post_reset_run: got %b want 1100000000", {done0, pass0, ec0}); end
  endtask

  initial begin
    test_reset();
    test_dff_pass();
    test_stuck_bit();
    test_srffe();
    test_enable_hold();
    test_saturate();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
